alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: req0 / req1  input  1 each  requester x asks for one ALU operation.
REQ-004 SHALL have port: func0 / func1  input  3 each  ALU function code for requester x.
REQ-005 SHALL have port: opa0 / opa1  input  4 each  operand A for requester x.
REQ-006 SHALL have port: gnt0 / gnt1  output  1 each  one-cycle pulse; requester x's command was accepted.
REQ-007 SHALL have port: done0 / done1  output  1 each  one-cycle pulse; acc x holds the new result.
REQ-008 SHALL have port: acc0 / acc1  output  8 each  per-requester accumulator, registered.
REQ-009 SHALL have port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 SHALL share one combinational ALU between two requesters, each owning a private 8-bit accumulator.
REQ-011 The ALU SHALL take A = latched opa and B = acc_x[3:0] of the granted requester.
REQ-012 The ALU SHALL produce an 8-bit result for each func code:
  - 000: A+1, zero-extended
  - 001: A+B, 5-bit sum with carry
  - 010: A+B
  - 011: {A|B, A^B}
  - 100: reduction-OR of {A,B}, LSB only
  - 101: B<<A
  - 110: B>>A
  - 111: A*B
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE, with transitions IDLE->EXEC on any req, EXEC->DONE always, and DONE->IDLE always.
REQ-014 In IDLE with any req high, the block SHALL choose a winner, latch that winner's func/opa, and enter EXEC next cycle.
REQ-015 Arbitration SHALL be round-robin: on a simultaneous request, the requester not served last wins.
REQ-016 The last-served pointer SHALL update only on grant.
REQ-017 gnt_x SHALL be high for exactly the EXEC cycle of requester x.
REQ-018 The ALU result SHALL be written to acc_x at the end of EXEC.
REQ-019 done_x SHALL be high for exactly the DONE cycle, with acc_x already showing the new value.
REQ-020 Latency SHALL be: req sampled in cycle n, gnt in n+1, done and updated acc in n+2, next arbitration in n+3.
REQ-021 Throughput SHALL be one operation per 3 cycles.
REQ-022 A requester SHALL hold req, func and opa stable until gnt.
REQ-023 Changes to func/opa after the IDLE sample SHALL NOT affect the operation in progress.
REQ-024 Requests arriving during EXEC or DONE SHALL be ignored until IDLE.
REQ-025 A req still high in the cycle after done SHALL be treated as a new request.
REQ-026 The accumulator of the non-granted requester SHALL never change.
REQ-027 Results SHALL be truncated to 8 bits (A*B max 225 and B<<A mod 256).
REQ-028 gnt0 and gnt1 SHALL never both be high; done0 and done1 SHALL never both be high.

Reset
REQ-029 On reset_n=0 at a clk edge, the block SHALL force:
  - state to IDLE
  - acc0 and acc1 to 8'h00
  - gnt, done and busy to 0
  - pointer so that port 0 wins the first tie
REQ-030 A reset during EXEC or DONE SHALL abort the operation: no done pulse and no accumulator write.

Structure
REQ-031 A shared package SHALL hold the func-code constants (8 codes) and the FSM state encoding.
REQ-032 The ALU SHALL be a purely combinational sub-module named alu_core, instantiated once.

Verification
REQ-033 After reset, req0 with func=000 and opa=5 SHALL give gnt0 at +1, done0 at +2, and acc0=8'h06.
REQ-034 With acc0=06, req0 with func=111 and opa=3 SHALL give acc0=8'h12, with acc1 unchanged at 00.
REQ-035 After reset, req0 and req1 together with func=010 and opa=1 SHALL be served port0 then port1, giving acc0=acc1=01; a second tie SHALL serve port1 first.
REQ-036 With acc1=0F, req1 with func=001 and opa=F SHALL give acc1=8'h1E; with func=101, opa=4 and B=1 it SHALL give acc1=8'h10.
REQ-037 reset_n low during EXEC of req0 SHALL give no done0, acc0=00 and busy=0 next cycle.
REQ-038 Changing opa0 from 2 to 7 during EXEC SHALL leave the result computed with 2.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU function codes and FSM state encoding for the ALU arbiter.
// No logic; constants only.
// No flow control.
package alu_arbiter_pkg;

    localparam logic [2:0] FN_INC   = 3'b000;
    localparam logic [2:0] FN_ADDC  = 3'b001;
    localparam logic [2:0] FN_ADD   = 3'b010;
    localparam logic [2:0] FN_ORXOR = 3'b011;
    localparam logic [2:0] FN_ROR   = 3'b100;
    localparam logic [2:0] FN_SHL   = 3'b101;
    localparam logic [2:0] FN_SHR   = 3'b110;
    localparam logic [2:0] FN_MUL   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Shared 4-bit-operand ALU producing an 8-bit result.
// Latency: purely combinational.
// No flow control.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [2:0] func,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result
);

    logic [7:0] a_ext;
    logic [7:0] b_ext;

    assign a_ext = {4'b0000, a};
    assign b_ext = {4'b0000, b};

    always_comb begin
        result = 8'h00;
        case (func)
            FN_INC:   result = a_ext + 8'd1;
            FN_ADDC:  result = a_ext + b_ext;
            FN_ADD:   result = a_ext + b_ext;
            FN_ORXOR: result = {a | b, a ^ b};
            FN_ROR:   result = {7'b0000000, |{a, b}};
            FN_SHL:   result = b_ext << a;
            FN_SHR:   result = b_ext >> a;
            FN_MUL:   result = a_ext * b_ext;
            default:  result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two private accumulators.
// Latency: req sampled at n, gnt at n+1, done + updated acc at n+2, next arbitration n+3.
// Requests outside IDLE are ignored; a requester holds req/func/opa until gnt.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] func0,
    input  logic [2:0] func1,
    input  logic [3:0] opa0,
    input  logic [3:0] opa1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] acc0,
    output logic [7:0] acc1,
    output logic       busy
);

    logic [1:0] state;
    logic       owner;
    logic       last_served;
    logic       winner;
    logic [2:0] func_q;
    logic [3:0] opa_q;
    logic [3:0] alu_b;
    logic [7:0] alu_result;

    // On a tie the port not served last wins; otherwise the lone requester.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_served;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    assign alu_b = owner ? acc1[3:0] : acc0[3:0];

    alu_core u_alu_core (
        .func   (func_q),
        .a      (opa_q),
        .b      (alu_b),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            func_q      <= 3'b000;
            opa_q       <= 4'h0;
            acc0        <= 8'h00;
            acc1        <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state       <= ST_EXEC;
                        owner       <= winner;
                        last_served <= winner;
                        func_q      <= winner ? func1 : func0;
                        opa_q       <= winner ? opa1 : opa0;
                    end
                end
                ST_EXEC: begin
                    state <= ST_DONE;
                    if (owner) begin
                        acc1 <= alu_result;
                    end else begin
                        acc0 <= alu_result;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0  = (state == ST_EXEC) && !owner;
    assign gnt1  = (state == ST_EXEC) &&  owner;
    assign done0 = (state == ST_DONE) && !owner;
    assign done1 = (state == ST_DONE) &&  owner;
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single operations plus tie, reset-abort
// and operand-change sequences.
module tb_alu_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0, req1;
    logic [2:0] func0, func1;
    logic [3:0] opa0, opa1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] acc0, acc1;

    int n_vec;
    int n_err;
    logic [7:0] mdl_acc [2];

    typedef struct {
        bit         port;
        logic [2:0] func;
        logic [3:0] opa;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [17];

    alu_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .func0   (func0),
        .func1   (func1),
        .opa0    (opa0),
        .opa1    (opa1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .acc0    (acc0),
        .acc1    (acc1),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; pulses must be exclusive.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_exclusive", {7'b0, gnt0 & gnt1}, 8'h00);
        chk("done_exclusive", {7'b0, done0 & done1}, 8'h00);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mdl_acc[0] = 8'h00;
        mdl_acc[1] = 8'h00;
    endtask

    task automatic run_op(input int idx, input bit port, input logic [2:0] f,
                          input logic [3:0] a, input logic [7:0] exp);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (port) begin
            req1 = 1'b1; func1 = f; opa1 = a;
        end else begin
            req0 = 1'b1; func0 = f; opa0 = a;
        end
        tick();
        chk({tag, "_gnt"}, {6'b0, gnt1, gnt0}, port ? 8'h02 : 8'h01);
        chk({tag, "_busy_exec"}, {7'b0, busy}, 8'h01);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk({tag, "_done"}, {6'b0, done1, done0}, port ? 8'h02 : 8'h01);
        mdl_acc[port] = exp;
        chk({tag, "_acc"}, port ? acc1 : acc0, exp);
        chk({tag, "_other_acc"}, port ? acc0 : acc1, mdl_acc[~port]);
        tick();
        chk({tag, "_idle"}, {5'b0, busy, done1, done0}, 8'h00);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        func0 = 3'b000; func1 = 3'b000;
        opa0 = 4'h0; opa1 = 4'h0;

        tbl[0]  = '{1'b0, 3'b000, 4'h5, 8'h06};
        tbl[1]  = '{1'b0, 3'b111, 4'h3, 8'h12};
        tbl[2]  = '{1'b1, 3'b000, 4'hE, 8'h0F};
        tbl[3]  = '{1'b1, 3'b001, 4'hF, 8'h1E};
        tbl[4]  = '{1'b1, 3'b110, 4'h3, 8'h01};
        tbl[5]  = '{1'b1, 3'b101, 4'h4, 8'h10};
        tbl[6]  = '{1'b0, 3'b011, 4'h9, 8'hBB};
        tbl[7]  = '{1'b0, 3'b100, 4'h0, 8'h01};
        tbl[8]  = '{1'b0, 3'b010, 4'hF, 8'h10};
        tbl[9]  = '{1'b0, 3'b100, 4'h0, 8'h00};
        tbl[10] = '{1'b0, 3'b000, 4'hF, 8'h10};
        tbl[11] = '{1'b0, 3'b010, 4'h5, 8'h05};
        tbl[12] = '{1'b0, 3'b111, 4'hF, 8'h4B};
        tbl[13] = '{1'b0, 3'b101, 4'h7, 8'h80};
        tbl[14] = '{1'b1, 3'b000, 4'hE, 8'h0F};
        tbl[15] = '{1'b1, 3'b111, 4'hF, 8'hE1};
        tbl[16] = '{1'b1, 3'b110, 4'h0, 8'h01};

        do_reset();
        chk("reset_acc0", acc0, 8'h00);
        chk("reset_acc1", acc1, 8'h00);
        chk("reset_flags", {3'b0, busy, gnt1, gnt0, done1, done0}, 8'h00);

        for (int i = 0; i < 17; i++) begin
            run_op(i, tbl[i].port, tbl[i].func, tbl[i].opa, tbl[i].exp);
        end

        // Both ports hold req: port0 first, then port1, then port0 again.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        func0 = 3'b010; func1 = 3'b010;
        opa0 = 4'h1; opa1 = 4'h1;
        tick();
        chk("tie1_gnt", {6'b0, gnt1, gnt0}, 8'h01);
        tick();
        chk("tie1_acc0", acc0, 8'h01);
        chk("tie1_acc1", acc1, 8'h00);
        tick();
        chk("tie1_idle", {7'b0, busy}, 8'h00);
        tick();
        chk("tie2_gnt", {6'b0, gnt1, gnt0}, 8'h02);
        tick();
        chk("tie2_done", {6'b0, done1, done0}, 8'h02);
        chk("tie2_acc1", acc1, 8'h01);
        chk("tie2_acc0", acc0, 8'h01);
        tick();
        tick();
        chk("tie3_gnt", {6'b0, gnt1, gnt0}, 8'h01);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("tie3_acc0", acc0, 8'h02);
        chk("tie3_acc1", acc1, 8'h01);
        tick();

        // Reset during EXEC aborts the operation.
        req0 = 1'b1; func0 = 3'b000; opa0 = 4'h5;
        tick();
        chk("abort_gnt", {6'b0, gnt1, gnt0}, 8'h01);
        reset_n = 1'b0;
        req0 = 1'b0;
        tick();
        chk("abort_done", {6'b0, done1, done0}, 8'h00);
        chk("abort_acc0", acc0, 8'h00);
        chk("abort_busy", {7'b0, busy}, 8'h00);
        reset_n = 1'b1;
        mdl_acc[0] = 8'h00;
        mdl_acc[1] = 8'h00;
        tick();
        chk("abort_still_idle", {7'b0, busy}, 8'h00);

        // Operand changes and a new request during EXEC/DONE have no effect.
        req0 = 1'b1; func0 = 3'b010; opa0 = 4'h2;
        tick();
        chk("latch_gnt", {6'b0, gnt1, gnt0}, 8'h01);
        req0 = 1'b0; opa0 = 4'h7; func0 = 3'b111;
        req1 = 1'b1; func1 = 3'b000; opa1 = 4'h1;
        tick();
        chk("latch_done", {6'b0, done1, done0}, 8'h01);
        chk("latch_acc0", acc0, 8'h02);
        req1 = 1'b0;
        tick();
        chk("ignored_idle", {7'b0, busy}, 8'h00);
        tick();
        chk("ignored_no_gnt", {5'b0, busy, gnt1, gnt0}, 8'h00);
        chk("ignored_acc1", acc1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
